// File: rtl/motion_pkg.sv
// motion_pkg: shared state encodings and H-bridge leg patterns for the
// motion driver. Leg patterns are ordered {left_fwd, left_rev, right_fwd, right_rev}.
package motion_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t FWD       = 3'd1;
    localparam state_t DEAD      = 3'd2;
    localparam state_t TURN      = 3'd3;
    localparam state_t TURN_DONE = 3'd4;

    localparam logic [3:0] LEGS_OFF     = 4'b0000;
    localparam logic [3:0] LEGS_FWD     = 4'b1010;
    localparam logic [3:0] LEGS_PIVOT_R = 4'b1001;

    // Ungated leg pattern driven in each state; only FWD and TURN drive legs.
    function automatic logic [3:0] legs_for_state(input state_t st);
        case (st)
            FWD:     legs_for_state = LEGS_FWD;
            TURN:    legs_for_state = LEGS_PIVOT_R;
            default: legs_for_state = LEGS_OFF;
        endcase
    endfunction

endpackage

// File: rtl/motion_pwm.sv
// motion_pwm: free-running PWM generator. A prescaler divides the clock by
// PWM_DIV, an 8-bit phase counter advances on each prescaler wrap, and the
// output is high while phase < current duty.
// Optional soft-start ramp is enabled by defining MOTION_SOFTSTART_EN.
module motion_pwm #(
    parameter logic [7:0] PWM_DIV = 8'd4,
    parameter logic [7:0] DUTY    = 8'd192
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart_ramp,
    output logic pwm_on
);

    logic [7:0] presc_q, presc_d;
    logic [7:0] phase_q, phase_d;
    logic       presc_wrap;
    logic [7:0] duty_cur;

    // Prescaler and phase next-state; phase only moves when the prescaler wraps.
    always_comb begin
        presc_wrap = (presc_q == PWM_DIV - 8'd1);
        presc_d    = presc_wrap ? 8'd0 : presc_q + 8'd1;
        phase_d    = presc_wrap ? phase_q + 8'd1 : phase_q;
    end

    // Prescaler and phase registers run free from reset, independent of motion state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= 8'd0;
            phase_q <= 8'd0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

`ifdef MOTION_SOFTSTART_EN
    logic [7:0] duty_q, duty_d;

    // Ramp restarts from zero on motion entry, then climbs one step per phase period up to DUTY.
    always_comb begin
        duty_d = duty_q;
        if (restart_ramp) begin
            duty_d = 8'd0;
        end else if (presc_wrap && (phase_q == 8'hFF) && (duty_q < DUTY)) begin
            duty_d = duty_q + 8'd1;
        end
    end

    // Soft-start duty register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            duty_q <= 8'd0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_cur = duty_q;
`else
    logic unused_restart_ramp;

    assign unused_restart_ramp = restart_ramp;
    assign duty_cur            = DUTY;
`endif

    assign pwm_on = (phase_q < duty_cur);

endmodule

// File: rtl/motion_driver.sv
// motion_driver: converts planner front/right/stop levels into PWM-gated
// H-bridge leg enables with dead-time before a pivot and a timed right turn.
// Define MOTION_SOFTSTART_EN to ramp PWM duty up after each motion start.
module motion_driver
    import motion_pkg::*;
#(
    parameter logic [23:0] TURN_CYCLES = 24'd6_000_000,
    parameter logic [15:0] DEADTIME    = 16'd500,
    parameter logic [7:0]  PWM_DIV     = 8'd4,
    parameter logic [7:0]  DUTY        = 8'd192
) (
    input  logic clock,
    input  logic reset_n,
    input  logic front,
    input  logic right,
    input  logic stop,
    output logic left_fwd,
    output logic left_rev,
    output logic right_fwd,
    output logic right_rev,
    output logic busy,
    output logic turn_done
);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        right_q, right_d;
    logic        turn_done_q, turn_done_d;
    logic        right_edge;
    logic        dead_last;
    logic        turn_last;
    logic        restart_ramp;
    logic        pwm_on;
    logic [3:0]  legs;

    motion_pwm #(
        .PWM_DIV (PWM_DIV),
        .DUTY    (DUTY)
    ) u_pwm (
        .clock        (clock),
        .reset_n      (reset_n),
        .restart_ramp (restart_ramp),
        .pwm_on       (pwm_on)
    );

    // State transitions: stop beats a right edge, which beats front.
    always_comb begin
        right_edge = right & ~right_q;
        dead_last  = (cnt_q == ({8'd0, DEADTIME} - 24'd1));
        turn_last  = (cnt_q == (TURN_CYCLES - 24'd1));
        state_d    = state_q;
        case (state_q)
            IDLE: begin
                if (stop)            state_d = IDLE;
                else if (right_edge) state_d = TURN;
                else if (front)      state_d = FWD;
            end
            FWD: begin
                if (stop)            state_d = IDLE;
                else if (right_edge) state_d = DEAD;
                else if (!front)     state_d = IDLE;
            end
            DEAD: begin
                if (stop)            state_d = IDLE;
                else if (dead_last)  state_d = TURN;
            end
            TURN: begin
                if (stop)            state_d = IDLE;
                else if (turn_last)  state_d = TURN_DONE;
            end
            TURN_DONE: begin
                if (stop || !right)  state_d = IDLE;
            end
            default:                 state_d = IDLE;
        endcase
    end

    // Counter clears on any state entry and only advances in the timed states.
    always_comb begin
        cnt_d        = 24'd0;
        turn_done_d  = (state_q == TURN) && (state_d == TURN_DONE);
        right_d      = right;
        restart_ramp = (state_d != state_q) && ((state_d == FWD) || (state_d == TURN));
        if ((state_d == state_q) && ((state_q == DEAD) || (state_q == TURN))) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // Control registers; right_q resets high so a level held from reset is not an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 24'd0;
            right_q     <= 1'b1;
            turn_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            right_q     <= right_d;
            turn_done_q <= turn_done_d;
        end
    end

    assign legs      = legs_for_state(state_q) & {4{pwm_on}};
    assign left_fwd  = legs[3];
    assign left_rev  = legs[2];
    assign right_fwd = legs[1];
    assign right_rev = legs[0];
    assign busy      = (state_q != IDLE);
    assign turn_done = turn_done_q;

endmodule

// File: tb/tb_motion_driver.sv
// tb_motion_driver: table-driven check of motion_driver with
// TURN_CYCLES=20, DEADTIME=4, PWM_DIV=1, DUTY=128, plus hand-written
// sequences for abort, turn length, duty, reset-held right and async reset.
// With MOTION_SOFTSTART_EN defined, duty windows follow the ramp.
module tb_motion_driver;

    localparam logic [3:0] P_OFF = 4'b0000;
    localparam logic [3:0] P_FWD = 4'b1010;
    localparam logic [3:0] P_PIV = 4'b1001;

    typedef struct {
        logic       f;
        logic       r;
        logic       s;
        logic [3:0] legs;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    logic clock;
    logic reset_n;
    logic front, right, stop;
    logic left_fwd, left_rev, right_fwd, right_rev;
    logic busy, turn_done;

    int checks = 0;
    int errors = 0;
    int ecount;

    motion_driver #(
        .TURN_CYCLES (24'd20),
        .DEADTIME    (16'd4),
        .PWM_DIV     (8'd1),
        .DUTY        (8'd128)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .front     (front),
        .right     (right),
        .stop      (stop),
        .left_fwd  (left_fwd),
        .left_rev  (left_rev),
        .right_fwd (right_fwd),
        .right_rev (right_rev),
        .busy      (busy),
        .turn_done (turn_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference PWM phase: with PWM_DIV=1 it equals clock edges since reset release.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ecount <= 0;
        else          ecount <= ecount + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic pwm_exp();
        return (ecount % 256) < 128;
    endfunction

    task automatic check_one(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic r, input logic s);
        front = f;
        right = r;
        stop  = s;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] pat, input logic b, input logic d);
        logic [3:0] act;
        act = {left_fwd, left_rev, right_fwd, right_rev};
`ifndef MOTION_SOFTSTART_EN
        check_one({name, "_legs"}, int'(act), int'(pat & {4{pwm_exp()}}));
`else
        check_one({name, "_legs"}, int'(act & ~pat), 0);
`endif
        check_one({name, "_busy"}, int'(busy), int'(b));
        check_one({name, "_done"}, int'(turn_done), int'(d));
    endtask

    task automatic add_rows(input logic f, input logic r, input logic s,
                            input logic [3:0] legs, input logic b, input logic d, input int n);
        vec_t v;
        v.f = f; v.r = r; v.s = s; v.legs = legs; v.busy = b; v.done = d;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic measure_window(input string name, input int expected);
        int on_l, on_r, rev;
        on_l = 0; on_r = 0; rev = 0;
        for (int i = 0; i < 256; i++) begin
            on_l += int'(left_fwd);
            on_r += int'(right_fwd);
            rev  += int'(left_rev | right_rev);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        check_one({name, "_left_on"}, on_l, expected);
        check_one({name, "_right_on"}, on_r, expected);
        check_one({name, "_rev"}, rev, 0);
    endtask

    initial begin
        int n;
        int seen;
        int guard;

        // Main vector table: reset with front held, FWD, DEAD, TURN, TURN_DONE, priorities.
        add_rows(1, 0, 0, P_FWD, 1, 0, 3);
        add_rows(1, 1, 0, P_OFF, 1, 0, 4);
        add_rows(1, 1, 0, P_PIV, 1, 0, 20);
        add_rows(1, 1, 0, P_OFF, 1, 1, 1);
        add_rows(1, 1, 0, P_OFF, 1, 0, 2);
        add_rows(0, 0, 0, P_OFF, 0, 0, 3);
        add_rows(1, 0, 1, P_OFF, 0, 0, 2);
        add_rows(1, 1, 0, P_PIV, 1, 0, 1);
        add_rows(1, 1, 1, P_OFF, 0, 0, 1);
        add_rows(1, 1, 0, P_FWD, 1, 0, 2);
        add_rows(0, 1, 0, P_OFF, 0, 0, 1);
        add_rows(0, 0, 0, P_OFF, 0, 0, 1);
        add_rows(1, 0, 0, P_FWD, 1, 0, 2);
        add_rows(1, 0, 1, P_OFF, 0, 0, 1);
        add_rows(0, 0, 0, P_OFF, 0, 0, 1);

        front = 1'b1; right = 1'b0; stop = 1'b0; reset_n = 1'b0;
        #12;
        checkOutput("reset", P_OFF, 1'b0, 1'b0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].f, vecs[i].r, vecs[i].s);
            checkOutput($sformatf("vec%0d", i), vecs[i].legs, vecs[i].busy, vecs[i].done);
        end

        // Abort a pivot with stop at count 10: no turn_done, no retrigger.
        applyStimulus(0, 1, 0);
        checkOutput("abort_enter", P_PIV, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 1);
        checkOutput("abort_stop", P_OFF, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 1, 0);
            seen += int'(turn_done) + int'(busy);
        end
        check_one("abort_quiet", seen, 0);
        applyStimulus(0, 0, 0);

        // Turn length measured from entry to the turn_done pulse.
        applyStimulus(0, 1, 0);
        n = 0;
        while (!turn_done && n < 100) begin
            applyStimulus(0, 1, 0);
            n++;
        end
        check_one("turn_len", n, 20);
        applyStimulus(0, 1, 0);
        checkOutput("done_single", P_OFF, 1'b1, 1'b0);
        applyStimulus(0, 0, 0);
        checkOutput("done_release", P_OFF, 1'b0, 1'b0);

        // Duty windows aligned to phase 0 while in FWD.
        applyStimulus(1, 0, 0);
        guard = 0;
        while ((ecount % 256) != 0 && guard < 300) begin
            applyStimulus(1, 0, 0);
            guard++;
        end
        check_one("align_bound", int'(guard < 300), 1);
`ifdef MOTION_SOFTSTART_EN
        measure_window("duty_w1", 1);
        measure_window("duty_w2", 2);
`else
        measure_window("duty_w1", 128);
        measure_window("duty_w2", 128);
`endif

        // Async reset in the middle of DEAD, with right held through reset.
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        check_one("dead_busy", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        check_one("async_busy", int'(busy), 0);
        check_one("async_legs", int'({left_fwd, left_rev, right_fwd, right_rev}), 0);
        check_one("async_done", int'(turn_done), 0);
        front = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 1, 0);
            seen += int'(busy);
        end
        check_one("held_right_no_turn", seen, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("new_edge_turn", P_PIV, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 1, 0);
            seen += int'(turn_done);
        end
        check_one("one_turn_done", seen, 1);
        applyStimulus(0, 0, 0);
        checkOutput("final_idle", P_OFF, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
